rle_row_decoder: RTL
====================

Name: rle_row_decoder

Overview:
- Run-length decoder directly upstream of the DMA stage. It consumes the CPU's compressed image stream one code word at a time and rebuilds full binary image rows of ROW_SIZE pixels.
- Each completed row is presented to the DMA on decompressed_row. The row is held stable until the DMA signals it has written every block of that row to RAM.
- Runs may span row boundaries. Frame completion is flagged after NUM_ROWS rows.

Parameters:
- ROW_SIZE, 16, pixels per row; width of decompressed_row.
- CODE_W, 5, code word width. Bit CODE_W-1 is the pixel value; bits CODE_W-2..0 are the run count.
- NUM_ROWS, 16, rows per image frame.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  synchronous 1-cycle pulse that starts a new frame.
- in_valid  in  1  code word available.
- in_data  in  CODE_W  code word {value, count}.
- in_ready  out  1  decoder accepts in_data this cycle.
- row_valid  out  1  decompressed_row holds a complete row.
- decompressed_row  out  ROW_SIZE  row pixels. Pixel 0 is bit 0, matching the DMA's low-block-first order.
- row_ack  in  1  DMA done pulse; current row consumed.
- row_count  out  clog2(NUM_ROWS+1)  rows acknowledged in the current frame.
- frame_done  out  1  all NUM_ROWS rows acknowledged.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - Outputs zero: in_ready, row_valid, decompressed_row, row_count, frame_done.
  - Internal fill=0, run_left=0.
  - rst has priority over load. load has priority over every other event, in every state.
- load: same clearing as reset, then state=FETCH. Any in-flight row or run is discarded.
- Internal registers:
  - run_val (1 bit).
  - run_left (CODE_W-1 bits).
  - fill (clog2(ROW_SIZE+1) bits).
  - row register driven directly onto decompressed_row.
- in_ready=1 only in FETCH. A word transfers when in_valid and in_ready are both 1 at posedge.
- FETCH:
  - On transfer: run_val<=in_data[CODE_W-1]; run_left<=in_data[CODE_W-2:0].
  - If count==0, the word is consumed with no pixels and the block stays in FETCH. Otherwise go to FILL.
- FILL (one cycle per row segment):
  - k = min(run_left, ROW_SIZE-fill).
  - Bits [fill, fill+k-1] of the row register <= run_val. Other bits are unchanged.
  - fill+=k; run_left-=k.
  - If fill reaches ROW_SIZE, go to HOLD. Else if run_left reaches 0, go to FETCH.
  - A run never fills more than one row per cycle.
- HOLD:
  - row_valid=1; decompressed_row is held stable; in_ready=0.
  - row_ack while not in HOLD is ignored.
  - On row_ack: row_valid<=0, row register<=0, fill<=0, row_count+=1. Then:
    - if row_count+1==NUM_ROWS, go to DONE;
    - else if run_left>0, go to FILL (run continues into the next row);
    - else go to FETCH.
- DONE:
  - frame_done=1 and in_ready=0.
  - Leftover run_left is discarded; extra input words are not accepted.
  - The block stays in DONE until load or rst.
- IDLE: in_ready=0 and no activity until load.
- Latency:
  - Word accepted at edge t; its pixels are written at edge t+1 (FILL).
  - row_valid is high from the edge after the last fill.
  - Minimum 2 cycles per code word that does not complete a row.
- Width rules:
  - All fill/k arithmetic is unsigned at clog2(ROW_SIZE+1) bits.
  - k ≤ ROW_SIZE, so fill never exceeds ROW_SIZE.

Decomposition:
- Package rle_pkg:
  - state enum {IDLE, FETCH, FILL, HOLD, DONE};
  - localparams VAL_BIT=CODE_W-1 and CNT_W=CODE_W-1;
  - FILL_W=clog2(ROW_SIZE+1).
- Sub-module run_mask_gen (combinational):
  - inputs fill and k;
  - output ROW_SIZE-bit mask with ones in [fill, fill+k-1].
  - Update rule: row = (row & ~mask) | (run_val ? mask : 0).

Test Plan (ROW_SIZE=16, CODE_W=5, NUM_ROWS=2 unless noted):
1. rst, load, words 0x08 then 0x18, row_ack one cycle after row_valid -> decompressed_row=0xFF00, row_count=1.
2. Words 0x1F, 0x03, 0x10, 0x0E -> row0=0x7FFF; after ack, row1 bits[1:0]=0, bits[15:2]=0 -> row1=0x0000 after the 0x0E run. Confirm the leftover of 0x03 continues into row1 without a FETCH.
3. Word 0x00 between valid words -> consumed in 1 cycle, no pixel change, in_ready stays 1.
4. Hold row_ack low for 5 cycles in HOLD while in_valid=1 -> in_ready=0 and decompressed_row stable all 5 cycles.
5. Two full rows acked -> frame_done=1, row_count=2, in_ready=0 with in_valid still asserted; load pulse -> frame_done=0, row_count=0, state FETCH.
6. load mid-FILL with fill=7, and rst asserted together with load -> everything zero, state IDLE (rst wins); row_ack pulsed in FETCH -> ignored, row_count unchanged.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types and default geometry for the run-length row decoder.
package rle_pkg;

  localparam int unsigned ROW_SIZE_DEF = 16;
  localparam int unsigned CODE_W_DEF   = 5;
  localparam int unsigned NUM_ROWS_DEF = 16;

  localparam int unsigned VAL_BIT = CODE_W_DEF - 1;
  localparam int unsigned CNT_W   = CODE_W_DEF - 1;
  localparam int unsigned FILL_W  = $clog2(ROW_SIZE_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FILL,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/run_mask_gen.sv
// Combinational mask with ones over the row segment [fill, fill+k-1].
module run_mask_gen #(
  parameter int unsigned ROW_SIZE = 16,
  parameter int unsigned FILL_W   = 5
) (
  input  logic [FILL_W-1:0]   i_fill,
  input  logic [FILL_W-1:0]   i_k,
  output logic [ROW_SIZE-1:0] o_mask_c
);

  logic [FILL_W:0] w_end;

  assign w_end = (FILL_W+1)'(i_fill) + (FILL_W+1)'(i_k);

  always_comb begin
    o_mask_c = '0;
    for (int i = 0; i < ROW_SIZE; i++) begin
      o_mask_c[i] = ((FILL_W+1)'(i) >= (FILL_W+1)'(i_fill)) && ((FILL_W+1)'(i) < w_end);
    end
  end

endmodule

// File: rtl/rle_row_decoder.sv
// Run-length decoder rebuilding binary image rows for the downstream DMA.
module rle_row_decoder
  import rle_pkg::*;
#(
  parameter int unsigned ROW_SIZE = ROW_SIZE_DEF,
  parameter int unsigned CODE_W   = CODE_W_DEF,
  parameter int unsigned NUM_ROWS = NUM_ROWS_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic                              in_valid,
  input  logic [CODE_W-1:0]                 in_data,
  output logic                              in_ready,
  output logic                              row_valid,
  output logic [ROW_SIZE-1:0]               decompressed_row,
  input  logic                              row_ack,
  output logic [$clog2(NUM_ROWS+1)-1:0]     row_count,
  output logic                              frame_done
);

  localparam int unsigned RUN_W = CODE_W - 1;
  localparam int unsigned FW    = $clog2(ROW_SIZE + 1);
  localparam int unsigned CMP_W = (RUN_W > FW) ? RUN_W : FW;
  localparam int unsigned RC_W  = $clog2(NUM_ROWS + 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_run_val;
  logic [RUN_W-1:0]    r_run_left;
  logic [FW-1:0]       r_fill;
  logic [ROW_SIZE-1:0] r_row;
  logic [RC_W-1:0]     r_row_count;
  logic                r_in_ready;
  logic                r_row_valid;
  logic                r_frame_done;

  logic                w_xfer;
  logic [CMP_W-1:0]    w_room;
  logic [CMP_W-1:0]    w_run_ext;
  logic [CMP_W-1:0]    w_k_full;
  logic [FW-1:0]       w_k;
  logic [FW-1:0]       w_fill_nxt;
  logic [RUN_W-1:0]    w_run_nxt;
  logic [ROW_SIZE-1:0] w_mask;

  assign in_ready         = r_in_ready;
  assign row_valid        = r_row_valid;
  assign decompressed_row = r_row;
  assign row_count        = r_row_count;
  assign frame_done       = r_frame_done;

  assign w_xfer = in_valid & r_in_ready;

  // Segment length: the rest of the run, clipped to the space left in the row.
  always_comb begin
    w_room     = CMP_W'(ROW_SIZE) - CMP_W'(r_fill);
    w_run_ext  = CMP_W'(r_run_left);
    w_k_full   = (w_run_ext < w_room) ? w_run_ext : w_room;
    w_k        = FW'(w_k_full);
    w_fill_nxt = r_fill + w_k;
    w_run_nxt  = RUN_W'(w_run_ext - w_k_full);
  end

  run_mask_gen #(
    .ROW_SIZE (ROW_SIZE),
    .FILL_W   (FW)
  ) u_mask (
    .i_fill   (r_fill),
    .i_k      (w_k),
    .o_mask_c (w_mask)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH: begin
        if (w_xfer && (in_data[RUN_W-1:0] != '0)) w_next = FILL;
      end
      FILL: begin
        if (w_fill_nxt == FW'(ROW_SIZE)) w_next = HOLD;
        else if (w_run_nxt == '0)        w_next = FETCH;
      end
      HOLD: begin
        if (row_ack) begin
          if (r_row_count + RC_W'(1) == RC_W'(NUM_ROWS)) w_next = DONE;
          else if (r_run_left != '0)                    w_next = FILL;
          else                                          w_next = FETCH;
        end
      end
      default: w_next = r_state;
    endcase
    if (load) w_next = FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Datapath and registered status flags; load restarts the frame from FETCH.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_run_val    <= 1'b0;
      r_run_left   <= '0;
      r_fill       <= '0;
      r_row        <= '0;
      r_row_count  <= '0;
      r_in_ready   <= !rst;
      r_row_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_in_ready   <= (w_next == FETCH);
      r_row_valid  <= (w_next == HOLD);
      r_frame_done <= (w_next == DONE);
      case (r_state)
        FETCH: begin
          if (w_xfer) begin
            r_run_val  <= in_data[CODE_W-1];
            r_run_left <= in_data[RUN_W-1:0];
          end
        end
        FILL: begin
          r_row      <= (r_row & ~w_mask) | (r_run_val ? w_mask : '0);
          r_fill     <= w_fill_nxt;
          r_run_left <= w_run_nxt;
        end
        HOLD: begin
          if (row_ack) begin
            r_row       <= '0;
            r_fill      <= '0;
            r_row_count <= r_row_count + RC_W'(1);
            if (w_next == DONE) r_run_left <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
